multi_digit_counter: RTL and testbench

Parametrised cascaded up/down counter of NUM_DIGITS 4-bit digits, each counting modulo 10 (BCD) or modulo 16 (hex) under a runtime mode select. It adds synchronous parallel load, a ripple-free digit carry/borrow chain, a combinational terminal-count output for cascading and a registered wrap pulse. It sits between the board clock/enable logic and the seven-segment display driver, and replaces the single-digit counter.

---
 rtl/counter_pkg.sv | 19 +
 rtl/counter_digit.sv | 58 +++++
 rtl/multi_digit_counter.sv | 64 ++++++
 tb/tb_multi_digit_counter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the multi-digit counter
package counter_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DEC_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] HEX_MAX = 4'd15;

    localparam logic TYPE_DEC = 1'b0;
    localparam logic TYPE_HEX = 1'b1;
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Largest legal digit value for the selected counting base
    function automatic logic [DIGIT_W-1:0] digit_max(input logic type_sel);
        return (type_sel == TYPE_HEX) ? HEX_MAX : DEC_MAX;
    endfunction

endpackage

// File: rtl/counter_digit.sv
// rtl/counter_digit.sv - one 4-bit BCD/hex up/down digit cell
module counter_digit
    import counter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic               type_sel,
    input  logic               updown,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    output logic [DIGIT_W-1:0] digit,
    output logic               term,
    output logic               carry
);

    logic [DIGIT_W-1:0] dmax;

    assign dmax = digit_max(type_sel);

    // Terminal flag for eout: an out-of-range decimal digit is never terminal.
    // Carry flag for the chain: a step from here rolls this digit over
    // (to 0 going up, including out-of-range digits; from 0 going down).
    always_comb begin
        term  = 1'b0;
        carry = 1'b0;
        if (updown == DIR_DOWN) begin
            term  = (digit == '0);
            carry = (digit == '0);
        end else begin
            term  = (digit == dmax);
            carry = (digit >= dmax);
        end
    end

    // Digit register: load has priority over step; out-of-range digits are
    // forced back into range on their next step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_digit;
        end else if (step) begin
            if (updown == DIR_DOWN) begin
                if (digit == '0 || digit > dmax)
                    digit <= dmax;
                else
                    digit <= digit - 4'd1;
            end else begin
                if (digit >= dmax)
                    digit <= '0;
                else
                    digit <= digit + 4'd1;
            end
        end
    end

endmodule

// File: rtl/multi_digit_counter.sv
// rtl/multi_digit_counter.sv - cascaded BCD/hex up/down counter with load, eout and wrap
module multi_digit_counter
    import counter_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          type_sel,
    input  logic                          updown,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
    output logic [DIGIT_W*NUM_DIGITS-1:0] count,
    output logic                          eout,
    output logic                          wrap,
    output logic                          zero
);

    logic [NUM_DIGITS-1:0] step;
    logic [NUM_DIGITS-1:0] term;
    logic [NUM_DIGITS-1:0] carry;

    genvar k;
    generate
        for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
            counter_digit u_digit (
                .clk        (clk),
                .reset      (reset),
                .step       (step[k]),
                .type_sel   (type_sel),
                .updown     (updown),
                .load       (load),
                .load_digit (load_value[DIGIT_W*k +: DIGIT_W]),
                .digit      (count[DIGIT_W*k +: DIGIT_W]),
                .term       (term[k]),
                .carry      (carry[k])
            );
        end
    endgenerate

    // Step chain: digit k steps when counting is enabled and every lower digit rolls over
    always_comb begin
        logic acc;
        acc = enable & ~load;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            step[i] = acc;
            acc     = acc & carry[i];
        end
    end

    // Terminal count and zero detect, both combinational for cascading and display
    assign eout = enable & ~load & (&term);
    assign zero = (count == '0);

    // Wrap pulse: eout delayed by one edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wrap <= 1'b0;
        else
            wrap <= eout;
    end

endmodule

// File: tb/tb_multi_digit_counter.sv
// tb/tb_multi_digit_counter.sv - directed self-checking bench for multi_digit_counter
module tb_multi_digit_counter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        type_sel;
    logic        updown;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] count;
    logic        eout;
    logic        wrap;
    logic        zero;

    int n_tests;
    int n_fail;

    multi_digit_counter #(.NUM_DIGITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .type_sel   (type_sel),
        .updown     (updown),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .eout       (eout),
        .wrap       (wrap),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        type_sel   = 1'b0;
        updown     = 1'b0;
        load       = 1'b0;
        load_value = 16'h0000;

        #3;
        check("reset_count", count, 16'h0000);
        check("reset_wrap", {15'd0, wrap}, 16'h0000);
        check("reset_zero", {15'd0, zero}, 16'h0001);
        check("reset_eout", {15'd0, eout}, 16'h0000);
        tick();
        reset = 1'b0;

        // decimal up carry 0999 -> 1000
        load = 1'b1; load_value = 16'h0999;
        tick();
        check("load_0999", count, 16'h0999);
        load = 1'b0; enable = 1'b1;
        #1;
        check("dec_carry_eout", {15'd0, eout}, 16'h0000);
        tick();
        check("dec_carry_count", count, 16'h1000);
        check("dec_carry_wrap", {15'd0, wrap}, 16'h0000);

        // decimal up wrap 9999 -> 0000
        enable = 1'b0; load = 1'b1; load_value = 16'h9999;
        tick();
        load = 1'b0; enable = 1'b1;
        #1;
        check("dec_wrap_eout", {15'd0, eout}, 16'h0001);
        tick();
        check("dec_wrap_count", count, 16'h0000);
        check("dec_wrap_wrap", {15'd0, wrap}, 16'h0001);
        check("dec_wrap_zero", {15'd0, zero}, 16'h0001);
        enable = 1'b0;
        #1;
        check("idle_eout", {15'd0, eout}, 16'h0000);
        tick();
        check("dec_wrap_pulse_end", {15'd0, wrap}, 16'h0000);

        // hex down wrap 0000 -> FFFF -> FFFE
        type_sel = 1'b1; updown = 1'b1; enable = 1'b1;
        #1;
        check("hex_down_eout", {15'd0, eout}, 16'h0001);
        tick();
        check("hex_down_count", count, 16'hFFFF);
        check("hex_down_wrap", {15'd0, wrap}, 16'h0001);
        check("hex_down_nzero", {15'd0, zero}, 16'h0000);
        tick();
        check("hex_down_next", count, 16'hFFFE);
        check("hex_down_wrap_end", {15'd0, wrap}, 16'h0000);

        // hex up through a mid carry: 00FF -> 0100
        updown = 1'b0; enable = 1'b0; load = 1'b1; load_value = 16'h00FF;
        tick();
        load = 1'b0; enable = 1'b1;
        tick();
        check("hex_up_carry", count, 16'h0100);

        // out-of-range decimal digit, up then down
        type_sel = 1'b0; enable = 1'b0; load = 1'b1; load_value = 16'h000C;
        tick();
        check("load_000C", count, 16'h000C);
        load = 1'b0; enable = 1'b1;
        tick();
        check("oor_up", count, 16'h0010);
        enable = 1'b0; load = 1'b1;
        tick();
        load = 1'b0; updown = 1'b1; enable = 1'b1;
        tick();
        check("oor_down", count, 16'h0009);

        // load/enable collision then hold
        updown = 1'b0; load = 1'b1; enable = 1'b1; load_value = 16'h1234;
        #1;
        check("collide_eout", {15'd0, eout}, 16'h0000);
        tick();
        check("collide_count", count, 16'h1234);
        check("collide_wrap", {15'd0, wrap}, 16'h0000);
        load = 1'b0; enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold_count_%0d", i), count, 16'h1234);
            check($sformatf("hold_eout_%0d", i), {15'd0, eout}, 16'h0000);
        end

        // asynchronous reset mid-count
        load = 1'b1; load_value = 16'h0005;
        tick();
        load = 1'b0; enable = 1'b1;
        tick();
        check("pre_reset_count", count, 16'h0006);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_count", count, 16'h0000);
        check("async_reset_wrap", {15'd0, wrap}, 16'h0000);
        check("async_reset_zero", {15'd0, zero}, 16'h0001);
        tick();
        check("reset_held_count", count, 16'h0000);
        reset = 1'b0;
        tick();
        check("post_reset_count", count, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
